// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline-register definitions: the skid-buffer state encoding and the default widths.
// The IF/ID, ID/EX, EX/MEM and MEM/WB stage registers all use these.
package pipe_skid_reg_pkg;

  // The encoding equals the number of held entries, so occupancy is the state itself
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  localparam int DEFAULT_DATA_W = 384;
  localparam int DEFAULT_CNT_W  = 32;

  function automatic logic [1:0] occupancy_of(input skid_state_t s);
    return s;
  endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle for one side of a pipeline register.
// The master drives valid/data and the slave drives ready.
interface pipe_skid_reg_if #(
  parameter int DATA_W = pipe_skid_reg_pkg::DEFAULT_DATA_W
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipe_skid_reg_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = pipe_skid_reg_pkg::DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register with a registered in_ready, flush, and a stall-cycle counter.
// out_data is driven straight from the main register; the skid register absorbs one extra beat.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  pipe_skid_reg_if.slave   up,
  pipe_skid_reg_if.master  dn,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  skid_state_t       state_q;
  skid_state_t       state_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              ready_q;
  logic              accept;
  logic              consume;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid;

  assign up.ready  = ready_q;
  assign dn.valid  = (state_q != EMPTY);
  assign dn.data   = main_q;
  assign occupancy = occupancy_of(state_q);

  assign accept  = up.valid & ready_q;
  assign consume = dn.valid & dn.ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d      = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && consume) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (consume) begin
          state_d        = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // A redirect wins over any transfer in the same cycle
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != TWO);
      if (flush) begin
        main_q <= '0;
        skid_q <= '0;
      end else begin
        if (load_main_in) begin
          main_q <= up.data;
        end else if (load_main_skid) begin
          main_q <= skid_q;
        end
        if (load_skid) begin
          skid_q <= up.data;
        end
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (dn.valid & ~dn.ready),
    .count (stall_cnt)
  );

endmodule
